// File: rtl/cms_unmask_3rdorder.sv
// Share decoder for the 3rd-order CMS AND gadget: folds the four shares of one word
// into an accumulator, one share per cycle, and presents the unmasked result on valid/ready.
module cms_unmask_3rdorder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] S0_i,
    input  logic [WIDTH-1:0] S1_i,
    input  logic [WIDTH-1:0] S2_i,
    input  logic [WIDTH-1:0] S3_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready_o never looks at valid_i, and valid_o/data_o stay stable until ready_i is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;
    logic [WIDTH-1:0] sh3;
    logic [1:0]       k;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            sh1   <= '0;
            sh2   <= '0;
            sh3   <= '0;
            k     <= 2'd0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        acc   <= S0_i;
                        sh1   <= S1_i;
                        sh2   <= S2_i;
                        sh3   <= S3_i;
                        k     <= 2'd1;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    // Each share is cleared as soon as it has been absorbed.
                    case (k)
                        2'd1: begin
                            acc <= acc ^ sh1;
                            sh1 <= '0;
                        end
                        2'd2: begin
                            acc <= acc ^ sh2;
                            sh2 <= '0;
                        end
                        2'd3: begin
                            acc   <= acc ^ sh3;
                            sh3   <= '0;
                            state <= DONE;
                        end
                        default: ;
                    endcase
                    k <= k + 2'd1;
                end
                DONE: begin
                    if (ready_i) begin
                        acc   <= '0;
                        state <= IDLE;
                        if (count != {CNT_W{1'b1}})
                            count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o     = (state == IDLE);
    assign valid_o     = (state == DONE);
    assign data_o      = valid_o ? acc : '0;
    assign busy_o      = (state != IDLE);
    assign count_o     = count;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_cms_unmask_3rdorder.sv
// Bench for cms_unmask_3rdorder: a 1-bit/8-bit-count instance and an 8-bit/2-bit-count
// instance run in lockstep from the same stimulus (the narrow one sees bit 0 of each share).
module tb_cms_unmask_3rdorder;

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] exp;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid_i;
    logic       ready_i;
    logic [7:0] s0, s1, s2, s3;

    logic       rdy_a, vld_a, busy_a;
    logic [0:0] dat_a;
    logic [7:0] cnt_a;
    logic [1:0] st_a;

    logic       rdy_b, vld_b, busy_b;
    logic [7:0] dat_b;
    logic [1:0] cnt_b;
    logic [1:0] st_b;

    cms_unmask_3rdorder #(.WIDTH(1), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .S0_i(s0[0:0]), .S1_i(s1[0:0]), .S2_i(s2[0:0]), .S3_i(s3[0:0]),
        .valid_i(valid_i), .ready_o(rdy_a),
        .data_o(dat_a), .valid_o(vld_a), .ready_i(ready_i),
        .busy_o(busy_a), .count_o(cnt_a), .dbg_state_o(st_a)
    );

    cms_unmask_3rdorder #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .S0_i(s0), .S1_i(s1), .S2_i(s2), .S3_i(s3),
        .valid_i(valid_i), .ready_o(rdy_b),
        .data_o(dat_b), .valid_o(vld_b), .ready_i(ready_i),
        .busy_o(busy_b), .count_o(cnt_b), .dbg_state_o(st_b)
    );

    // scoreboard
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         exp_cnt_a = 0;
    int         exp_cnt_b = 0;
    vec_t       tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready_a"}, 32'(rdy_a), 32'd1);
        check({tag, "_ready_b"}, 32'(rdy_b), 32'd1);
        check({tag, "_valid_a"}, 32'(vld_a), 32'd0);
        check({tag, "_valid_b"}, 32'(vld_b), 32'd0);
        check({tag, "_data_a"}, 32'(dat_a), 32'd0);
        check({tag, "_data_b"}, 32'(dat_b), 32'd0);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        check({tag, "_count_a"}, 32'(cnt_a), 32'(exp_cnt_a));
        check({tag, "_count_b"}, 32'(cnt_b), 32'(exp_cnt_b));
    endtask

    task automatic check_fold(input string tag);
        check({tag, "_fold_ready_b"}, 32'(rdy_b), 32'd0);
        check({tag, "_fold_valid_a"}, 32'(vld_a), 32'd0);
        check({tag, "_fold_valid_b"}, 32'(vld_b), 32'd0);
        check({tag, "_fold_data_a"}, 32'(dat_a), 32'd0);
        check({tag, "_fold_data_b"}, 32'(dat_b), 32'd0);
        check({tag, "_fold_busy_a"}, 32'(busy_a), 32'd1);
    endtask

    task automatic check_done(input string tag, input logic [7:0] exp);
        check({tag, "_done_valid_a"}, 32'(vld_a), 32'd1);
        check({tag, "_done_valid_b"}, 32'(vld_b), 32'd1);
        check({tag, "_done_data_a"}, 32'(dat_a), 32'(exp[0]));
        check({tag, "_done_data_b"}, 32'(dat_b), 32'(exp));
        check({tag, "_done_ready_a"}, 32'(rdy_a), 32'd0);
        check({tag, "_done_busy_b"}, 32'(busy_b), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!(rdy_a && rdy_b) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready_timeout"}, 32'(rdy_a && rdy_b), 32'd1);
    endtask

    // driver: one word, optional backpressure of 'hold' cycles in DONE
    task automatic run_word(input string tag, input vec_t v, input int hold);
        logic [7:0] exp;
        exp_q.push_back(v.exp);
        wait_ready(tag);
        s0 = v.s0; s1 = v.s1; s2 = v.s2; s3 = v.s3;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_fold(tag);
            s0 = 8'($urandom); s1 = 8'($urandom); s2 = 8'($urandom); s3 = 8'($urandom);
            valid_i = 1'b1;
            ready_i = 1'b1;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        check_done(tag, exp);
        if (hold == 0) valid_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            ready_i = 1'b0;
            valid_i = 1'b1;
            s0 = 8'($urandom);
            @(negedge clk);
            check_done({tag, "_hold"}, exp);
        end
        ready_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        if (exp_cnt_a < 255) exp_cnt_a++;
        if (exp_cnt_b < 3) exp_cnt_b++;
        check_idle({tag, "_after"});
    endtask

    initial begin
        vec_t v;
        logic [3:0] b;

        // directed table: all 16 single-bit combinations, then wider patterns
        for (int i = 0; i < 16; i++) begin
            b = 4'(i);
            v.s0 = {7'd0, b[0]};
            v.s1 = {7'd0, b[1]};
            v.s2 = {7'd0, b[2]};
            v.s3 = {7'd0, b[3]};
            v.exp = {7'd0, ^b};
            tbl.push_back(v);
        end
        tbl.push_back('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00});
        tbl.push_back('{8'h80, 8'h01, 8'h00, 8'h00, 8'h81});
        tbl.push_back('{8'h12, 8'h34, 8'h56, 8'h78, 8'h08});

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_state", 32'(st_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_word("w1011", '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01}, 0);
        check("count_first", 32'(cnt_a), 32'd1);
        run_word("w1100", '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00}, 0);
        // A5 ^ 3C ^ 0F ^ FF
        run_word("bp", '{8'hA5, 8'h3C, 8'h0F, 8'hFF, 8'h69}, 6);

        foreach (tbl[i]) run_word($sformatf("tbl%0d", i), tbl[i], 0);
        check("count_b_saturated", 32'(cnt_b), 32'd3);
        check("count_a_running", 32'(cnt_a), 32'd22);

        // reset landing on the second fold cycle
        wait_ready("rst_mid");
        s0 = 8'hF0; s1 = 8'h0F; s2 = 8'h33; s3 = 8'h55;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        check_idle("rst_mid");
        check("rst_mid_state", 32'(st_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_mid_post");
        run_word("post_rst", '{8'hC3, 8'h5A, 8'h00, 8'h99, 8'h00}, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
